// File: rtl/common_pkg.sv
// Shared execute-stage types: ALU operation set, exec FSM states
// and the ctrl_ALU_op encoding driven by the main decoder.
package common_pkg;

    typedef enum logic [3:0] {
        ALU_ADD,
        ALU_SUB,
        ALU_SLL,
        ALU_SRL,
        ALU_SRA,
        ALU_SLT,
        ALU_SLTU,
        ALU_XOR,
        ALU_OR,
        ALU_AND,
        ALU_MUL,
        ALU_DIV,
        ALU_DIVU,
        ALU_REM,
        ALU_REMU,
        ALU_ILLEGAL
    } ALU_ctrl_t;

    typedef enum logic [1:0] {
        IDLE,
        MUL,
        DIV,
        DONE
    } alu_exec_state_t;

    localparam logic [1:0] ALU_OP_MEM    = 2'b00;
    localparam logic [1:0] ALU_OP_BRANCH = 2'b01;
    localparam logic [1:0] ALU_OP_RTYPE  = 2'b10;
    localparam logic [1:0] ALU_OP_ITYPE  = 2'b11;

    localparam logic [6:0] F7_BASE   = 7'b0000000;
    localparam logic [6:0] F7_ALT    = 7'b0100000;
    localparam logic [6:0] F7_MULDIV = 7'b0000001;

    function automatic ALU_ctrl_t base_op(input logic [2:0] f3);
        ALU_ctrl_t c;
        unique case (f3)
            3'b000: c = ALU_ADD;
            3'b001: c = ALU_SLL;
            3'b010: c = ALU_SLT;
            3'b011: c = ALU_SLTU;
            3'b100: c = ALU_XOR;
            3'b101: c = ALU_SRL;
            3'b110: c = ALU_OR;
            default: c = ALU_AND;
        endcase
        return c;
    endfunction

    function automatic logic is_div_op(input ALU_ctrl_t c);
        return (c == ALU_DIV) || (c == ALU_DIVU) ||
               (c == ALU_REM) || (c == ALU_REMU);
    endfunction

endpackage

// File: rtl/alu_exec_unit_mdu_iter.sv
// Iterative multiply/divide: shift-add MUL and restoring DIV/REM
// sharing one hi/lo shift pair; the last step is taken combinationally.
module mdu_iter
    import common_pkg::*;
#(
    parameter int XLEN = 64,
    parameter int SHW  = $clog2(XLEN)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            start,
    input  ALU_ctrl_t       op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic            done,
    output logic [XLEN-1:0] result
);

    logic            busy;
    logic            is_mul;
    logic            want_rem;
    logic            neg_q;
    logic            neg_r;
    logic [SHW-1:0]  cnt;
    logic [XLEN-1:0] hi;
    logic [XLEN-1:0] lo;
    logic [XLEN-1:0] dvs;
    logic [XLEN-1:0] hi_n;
    logic [XLEN-1:0] lo_n;
    logic [XLEN:0]   mul_sum;
    logic [XLEN:0]   rem_sh;
    logic            ge;
    logic            sgn;
    logic            a_neg;
    logic            b_neg;

    assign sgn   = (op == ALU_DIV) || (op == ALU_REM);
    assign a_neg = sgn & a[XLEN-1];
    assign b_neg = sgn & b[XLEN-1];
    assign done  = busy && (cnt == SHW'(XLEN - 1));

    always_comb begin
        mul_sum = {1'b0, hi} + (lo[0] ? {1'b0, dvs} : '0);
        rem_sh  = {hi, lo[XLEN-1]};
        ge      = rem_sh >= {1'b0, dvs};
        if (is_mul) begin
            hi_n = mul_sum[XLEN:1];
            lo_n = {mul_sum[0], lo[XLEN-1:1]};
        end else begin
            hi_n = ge ? rem_sh[XLEN-1:0] - dvs : rem_sh[XLEN-1:0];
            lo_n = {lo[XLEN-2:0], ge};
        end
    end

    // Sign fix-up applies to the output of the final step
    always_comb begin
        result = lo_n;
        if (!is_mul) begin
            if (want_rem) result = neg_r ? -hi_n : hi_n;
            else          result = neg_q ? -lo_n : lo_n;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy     <= 1'b0;
            is_mul   <= 1'b0;
            want_rem <= 1'b0;
            neg_q    <= 1'b0;
            neg_r    <= 1'b0;
            cnt      <= '0;
            hi       <= '0;
            lo       <= '0;
            dvs      <= '0;
        end else if (flush) begin
            busy <= 1'b0;
        end else if (start) begin
            busy     <= 1'b1;
            is_mul   <= op == ALU_MUL;
            want_rem <= (op == ALU_REM) || (op == ALU_REMU);
            neg_q    <= a_neg ^ b_neg;
            neg_r    <= a_neg;
            cnt      <= '0;
            hi       <= '0;
            lo       <= a_neg ? -a : a;
            dvs      <= b_neg ? -b : b;
        end else if (busy) begin
            hi  <= hi_n;
            lo  <= lo_n;
            cnt <= cnt + 1'b1;
            if (done) busy <= 1'b0;
        end
    end

endmodule

// File: rtl/alu_exec_unit.sv
// Execute stage: decodes ALU_op/funct3/funct7, runs single-cycle ops
// inline and MUL/DIV/REM on mdu_iter, result held until consumed.
module alu_exec_unit
    import common_pkg::*;
#(
    parameter int   XLEN = 64,
    parameter bit   M_EN = 1'b1,
    localparam int  SHW  = $clog2(XLEN)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [1:0]      ctrl_ALU_op,
    input  logic [2:0]      funct3,
    input  logic [6:0]      funct7,
    input  logic [XLEN-1:0] operand_a,
    input  logic [XLEN-1:0] operand_b,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic            zero,
    output logic            illegal
);

    alu_exec_state_t state, state_n;
    ALU_ctrl_t       ctrl;
    logic [XLEN-1:0] alu_res;
    logic [XLEN-1:0] mdu_result;
    logic [SHW-1:0]  sh;
    logic            accept;
    logic            iter_op;
    logic            div0;
    logic            ovf;
    logic            mdu_done;

    always_comb begin
        ctrl = ALU_ILLEGAL;
        unique case (ctrl_ALU_op)
            ALU_OP_MEM:    ctrl = ALU_ADD;
            ALU_OP_BRANCH: ctrl = ALU_SUB;
            ALU_OP_RTYPE: begin
                if (funct7 == F7_BASE) begin
                    ctrl = base_op(funct3);
                end else if (funct7 == F7_ALT) begin
                    if (funct3 == 3'b000) ctrl = ALU_SUB;
                    if (funct3 == 3'b101) ctrl = ALU_SRA;
                end else if (funct7 == F7_MULDIV && M_EN) begin
                    unique case (funct3)
                        3'b000:  ctrl = ALU_MUL;
                        3'b100:  ctrl = ALU_DIV;
                        3'b101:  ctrl = ALU_DIVU;
                        3'b110:  ctrl = ALU_REM;
                        3'b111:  ctrl = ALU_REMU;
                        default: ctrl = ALU_ILLEGAL;
                    endcase
                end
            end
            default: begin
                ctrl = (funct3 == 3'b101 && funct7[5]) ? ALU_SRA
                                                       : base_op(funct3);
            end
        endcase
    end

    assign sh   = operand_b[SHW-1:0];
    assign div0 = operand_b == '0;
    assign ovf  = ((ctrl == ALU_DIV) || (ctrl == ALU_REM)) &&
                  (operand_a == {1'b1, {(XLEN-1){1'b0}}}) && (&operand_b);
    // Divide special cases bypass the iterator and finish in one cycle
    assign iter_op = (ctrl == ALU_MUL) || (is_div_op(ctrl) && !div0 && !ovf);

    always_comb begin
        alu_res = '0;
        unique case (ctrl)
            ALU_ADD:  alu_res = operand_a + operand_b;
            ALU_SUB:  alu_res = operand_a - operand_b;
            ALU_SLL:  alu_res = operand_a << sh;
            ALU_SRL:  alu_res = operand_a >> sh;
            ALU_SRA:  alu_res = $signed(operand_a) >>> sh;
            ALU_SLT:  alu_res = {{(XLEN-1){1'b0}},
                                 $signed(operand_a) < $signed(operand_b)};
            ALU_SLTU: alu_res = {{(XLEN-1){1'b0}}, operand_a < operand_b};
            ALU_XOR:  alu_res = operand_a ^ operand_b;
            ALU_OR:   alu_res = operand_a | operand_b;
            ALU_AND:  alu_res = operand_a & operand_b;
            ALU_DIV,
            ALU_DIVU: alu_res = div0 ? '1 : operand_a;
            ALU_REM,
            ALU_REMU: alu_res = div0 ? operand_a : '0;
            default:  alu_res = '0;
        endcase
    end

    assign in_ready  = !flush &&
                       ((state == IDLE) || (state == DONE && out_ready));
    assign accept    = in_valid && in_ready;
    assign out_valid = state == DONE;
    assign zero      = result == '0;

    mdu_iter #(
        .XLEN (XLEN),
        .SHW  (SHW)
    ) u_mdu (
        .clk    (clk),
        .rst_n  (rst_n),
        .flush  (flush),
        .start  (accept && iter_op),
        .op     (ctrl),
        .a      (operand_a),
        .b      (operand_b),
        .done   (mdu_done),
        .result (mdu_result)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_n;
    end

    always_comb begin
        state_n = state;
        if (flush) begin
            state_n = IDLE;
        end else begin
            unique case (state)
                IDLE, DONE: begin
                    if (state == DONE && out_ready) state_n = IDLE;
                    if (accept) begin
                        if (!iter_op)              state_n = DONE;
                        else if (ctrl == ALU_MUL)  state_n = MUL;
                        else                       state_n = DIV;
                    end
                end
                default: begin
                    if (mdu_done) state_n = DONE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            result  <= '0;
            illegal <= 1'b0;
        end else if (accept && !iter_op) begin
            result  <= alu_res;
            illegal <= ctrl == ALU_ILLEGAL;
        end else if (mdu_done && !flush) begin
            result  <= mdu_result;
            illegal <= 1'b0;
        end
    end

endmodule
